imm_decode_stage: RTL and testbench
===================================

IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 The block SHALL have parameter XLEN, default 32, meaning immediate/output data width; legal values 32 and 64.
REQ-002 The block SHALL have parameter CNT_W, default 16, meaning illegal-instruction counter width.
REQ-003 The block SHALL have parameter INST_WIDTH, default 32, meaning instruction width (fixed at 32).
REQ-004 The block SHALL have port clk_i, input, 1 bit, meaning the single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst_ni, input, 1 bit, meaning asynchronous, active-low reset.
REQ-006 The block SHALL have port flush_i, input, 1 bit, meaning synchronous discard of all buffered entries.
REQ-007 The block SHALL have port in_valid_i, input, 1 bit, meaning an upstream instruction is presented.
REQ-008 The block SHALL have port in_ready_o, output, 1 bit, meaning the block can accept an instruction.
REQ-009 The block SHALL have port in_inst_i, input, INST_WIDTH bits, meaning the raw instruction.
REQ-010 The block SHALL have port out_valid_o, output, 1 bit, meaning the output entry is valid.
REQ-011 The block SHALL have port out_ready_i, input, 1 bit, meaning downstream accepts the output entry.
REQ-012 The block SHALL have port out_inst_o, output, INST_WIDTH bits, meaning the instruction passed through unchanged.
REQ-013 The block SHALL have port out_imm_o, output, XLEN bits, meaning the sign-extended immediate.
REQ-014 The block SHALL have port out_fmt_o, output, 3 bits, meaning the format code: 0 R/none, 1 I, 2 S, 3 B, 4 U, 5 J, 7 invalid.
REQ-015 The block SHALL have port out_illegal_o, output, 1 bit, meaning the opcode is unrecognised.
REQ-016 The block SHALL have port illegal_cnt_o, output, CNT_W bits, meaning the saturating count of illegal instructions accepted.

Function
REQ-017 Decode SHALL use opcode inst[6:0]: I-format for 0000011, 0010011, 1100111, 1110011; S for 0100011; B for 1100011; U for 0110111, 0010111; J for 1101111; R for 0110011; every other value is invalid.
REQ-018 Immediates SHALL be: I = inst[31:20]; S = {inst[31:25], inst[11:7]}; B = {inst[31], inst[7], inst[30:25], inst[11:8], 0}; J = {inst[31], inst[19:12], inst[20], inst[30:21], 0}; U = {inst[31:12], 12'h000}; each sign-extended from its top bit to XLEN (U sign-extended from bit 31 when XLEN=64).
REQ-019 For R or invalid formats, out_imm_o SHALL be 0; for invalid, out_illegal_o=1 and out_fmt_o=7.
REQ-020 Storage SHALL be a 2-entry buffer (output register plus skid register) with FIFO ordering.
REQ-021 Latency SHALL be 1 cycle: a word accepted at edge N is visible on the outputs after edge N when the buffer was empty.
REQ-022 Throughput SHALL be one instruction per cycle while out_ready_i=1.
REQ-023 A transfer SHALL occur only when valid and ready are both 1 on the same edge, on each side independently.
REQ-024 in_ready_o SHALL equal NOT(skid register occupied), be registered, and never depend combinationally on out_ready_i.
REQ-025 While out_valid_o=1 and out_ready_i=0, all out_* signals SHALL hold stable.
REQ-026 When input and output transfers occur on the same edge, occupancy SHALL be unchanged and order SHALL be preserved.
REQ-027 With the buffer full, in_ready_o SHALL be 0 and no entry SHALL be overwritten.
REQ-028 flush_i=1 SHALL empty both entries at the next edge, giving out_valid_o=0 and in_ready_o=1 after that edge.
REQ-029 An input handshake on the same edge as flush_i SHALL be discarded and SHALL NOT increment the counter.
REQ-030 illegal_cnt_o SHALL increment by 1 per accepted non-discarded invalid instruction and saturate at 2^CNT_W-1.
REQ-031 flush_i SHALL NOT clear illegal_cnt_o.

Reset
REQ-032 While rst_ni=0, asynchronously: out_valid_o=0, in_ready_o=1, out_inst_o=0, out_imm_o=0, out_fmt_o=0, out_illegal_o=0, illegal_cnt_o=0, both buffer entries empty.
REQ-033 Reset asserted mid-transfer SHALL discard all buffered entries; no handshake completes on the edge where rst_ni=0.
REQ-034 After rst_ni deasserts, the first transfer SHALL be possible at the first rising edge.

Verification
REQ-035 The bench SHALL cover: XLEN=32, inst 0xFFF00093 (addi x1,x0,-1) -> imm 0xFFFFFFFF, fmt 1, illegal 0, one cycle after acceptance.
REQ-036 The bench SHALL cover: inst 0xFE112E23 (sw x1,-4(x2)) -> imm 0xFFFFFFFC, fmt 2.
REQ-037 The bench SHALL cover: XLEN=64, inst 0x800002B7 (lui x5,0x80000) -> imm 0xFFFFFFFF80000000, fmt 4.
REQ-038 The bench SHALL cover: back-to-back stream of 3 words with out_ready_i=0 -> two accepted, then in_ready_o=0; after out_ready_i=1 the words emerge in order with no loss and no duplication.
REQ-039 The bench SHALL cover: inst 0x0000007F -> fmt 7, illegal 1, imm 0, count 1; the same instruction with flush_i=1 on the accepting edge -> count unchanged, out_valid_o=0.
REQ-040 The bench SHALL cover: CNT_W=2 with five illegal instructions -> illegal_cnt_o saturates at 3; rst_ni pulse mid-stream -> all outputs return to their reset values immediately.

Source files
------------

// File: rtl/imm_decode_stage.sv
// Immediate decode stage: decodes the RISC-V instruction format and a
// sign-extended immediate, then buffers the result in a 2-entry skid buffer
// (output register + skid register). It also keeps a saturating count of
// illegal opcodes.
module imm_decode_stage #(
  parameter int XLEN       = 32,
  parameter int CNT_W      = 16,
  parameter int INST_WIDTH = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [INST_WIDTH-1:0] in_inst_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [INST_WIDTH-1:0] out_inst_o,
  output logic [XLEN-1:0]       out_imm_o,
  output logic [2:0]            out_fmt_o,
  output logic                  out_illegal_o,
  output logic [CNT_W-1:0]      illegal_cnt_o
);

  localparam logic [2:0] FMT_R   = 3'd0;
  localparam logic [2:0] FMT_I   = 3'd1;
  localparam logic [2:0] FMT_S   = 3'd2;
  localparam logic [2:0] FMT_B   = 3'd3;
  localparam logic [2:0] FMT_U   = 3'd4;
  localparam logic [2:0] FMT_J   = 3'd5;
  localparam logic [2:0] FMT_INV = 3'd7;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_OP     = 7'b0110011;

  typedef struct packed {
    logic [INST_WIDTH-1:0] inst;
    logic [XLEN-1:0]       imm;
    logic [2:0]            fmt;
    logic                  illegal;
  } entry_t;

  logic [31:0] inst;
  logic [31:0] imm32;
  logic [2:0]  dec_fmt;
  logic        dec_illegal;
  entry_t      dec;

  entry_t      out_q;
  entry_t      skid_q;
  logic        out_vld;
  logic        skid_vld;
  logic        in_fire;
  logic        out_fire;
  logic [CNT_W-1:0] cnt_q;

  assign inst = in_inst_i[31:0];

  // Format decode and 32-bit immediate assembly from the incoming word.
  always_comb begin
    imm32       = '0;
    dec_fmt     = FMT_R;
    dec_illegal = 1'b0;
    case (inst[6:0])
      OP_LOAD, OP_IMM, OP_JALR, OP_SYSTEM: begin
        dec_fmt = FMT_I;
        imm32   = {{20{inst[31]}}, inst[31:20]};
      end
      OP_STORE: begin
        dec_fmt = FMT_S;
        imm32   = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      end
      OP_BRANCH: begin
        dec_fmt = FMT_B;
        imm32   = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      end
      OP_LUI, OP_AUIPC: begin
        dec_fmt = FMT_U;
        imm32   = {inst[31:12], 12'h000};
      end
      OP_JAL: begin
        dec_fmt = FMT_J;
        imm32   = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      end
      OP_OP: begin
        dec_fmt = FMT_R;
      end
      default: begin
        dec_fmt     = FMT_INV;
        dec_illegal = 1'b1;
      end
    endcase
  end

  // Package the decoded fields; 32-bit immediate is sign-extended to XLEN.
  always_comb begin
    dec         = '0;
    dec.inst    = in_inst_i;
    dec.imm     = XLEN'($signed(imm32));
    dec.fmt     = dec_fmt;
    dec.illegal = dec_illegal;
  end

  // The skid register only fills while the output register is stalled, so
  // ready can come straight from its occupancy flop.
  assign in_fire  = in_valid_i & ~skid_vld;
  assign out_fire = out_vld & out_ready_i;

  // Two-entry buffer: output register refills from skid first, then input.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
      out_q    <= '0;
      skid_q   <= '0;
    end else if (flush_i) begin
      out_vld  <= 1'b0;
      skid_vld <= 1'b0;
    end else if (!out_vld) begin
      if (in_fire) begin
        out_q   <= dec;
        out_vld <= 1'b1;
      end
    end else if (skid_vld) begin
      if (out_fire) begin
        out_q    <= skid_q;
        skid_vld <= 1'b0;
      end
    end else begin
      if (out_fire && in_fire) begin
        out_q <= dec;
      end else if (out_fire) begin
        out_vld <= 1'b0;
      end else if (in_fire) begin
        skid_q   <= dec;
        skid_vld <= 1'b1;
      end
    end
  end

  // Saturating count of accepted illegal words; flush discards the word.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (in_fire && !flush_i && dec_illegal && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  assign in_ready_o    = ~skid_vld;
  assign out_valid_o   = out_vld;
  assign out_inst_o    = out_q.inst;
  assign out_imm_o     = out_q.imm;
  assign out_fmt_o     = out_q.fmt;
  assign out_illegal_o = out_q.illegal;
  assign illegal_cnt_o = cnt_q;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Bench for imm_decode_stage: two instances (XLEN=32/CNT_W=2 and
// XLEN=64/CNT_W=16) share one stimulus stream; a reference decoder feeds a
// scoreboard queue that a negedge monitor drains.
module tb_imm_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        flush_i;
  logic        in_valid_i;
  logic [31:0] in_inst_i;
  logic        out_ready_i;

  logic        in_ready_a, out_valid_a, ill_a;
  logic [31:0] inst_a, imm_a;
  logic [2:0]  fmt_a;
  logic [1:0]  cnt_a;

  logic        in_ready_b, out_valid_b, ill_b;
  logic [31:0] inst_b;
  logic [63:0] imm_b;
  logic [2:0]  fmt_b;
  logic [15:0] cnt_b;

  imm_decode_stage #(.XLEN(32), .CNT_W(2), .INST_WIDTH(32)) dut_a (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_a), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_a), .out_ready_i(out_ready_i), .out_inst_o(inst_a),
    .out_imm_o(imm_a), .out_fmt_o(fmt_a), .out_illegal_o(ill_a),
    .illegal_cnt_o(cnt_a)
  );

  imm_decode_stage #(.XLEN(64), .CNT_W(16), .INST_WIDTH(32)) dut_b (
    .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_b), .in_inst_i(in_inst_i),
    .out_valid_o(out_valid_b), .out_ready_i(out_ready_i), .out_inst_o(inst_b),
    .out_imm_o(imm_b), .out_fmt_o(fmt_b), .out_illegal_o(ill_b),
    .illegal_cnt_o(cnt_b)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [31:0] inst;
    logic [63:0] imm;
    logic [2:0]  fmt;
    logic        illegal;
  } exp_t;

  exp_t q[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   rst_count = 0;
  int   m_cnt_a = 0;
  int   m_cnt_b = 0;

  // Reference decoder written from the ISA immediate rules.
  function automatic exp_t ref_decode(input logic [31:0] w);
    exp_t e;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    e.inst = w; e.imm = 64'd0; e.fmt = 3'd0; e.illegal = 1'b0;
    s12 = {w[31:25], w[11:7]};
    b13 = {w[31], w[7], w[30:25], w[11:8], 1'b0};
    j21 = {w[31], w[19:12], w[20], w[30:21], 1'b0};
    case (w[6:0])
      7'h03, 7'h13, 7'h67, 7'h73: begin e.fmt = 3'd1; e.imm = longint'($signed(w[31:20])); end
      7'h23: begin e.fmt = 3'd2; e.imm = longint'($signed(s12)); end
      7'h63: begin e.fmt = 3'd3; e.imm = longint'($signed(b13)); end
      7'h37, 7'h17: begin e.fmt = 3'd4; e.imm = longint'($signed({w[31:12], 12'h000})); end
      7'h6F: begin e.fmt = 3'd5; e.imm = longint'($signed(j21)); end
      7'h33: e.fmt = 3'd0;
      default: begin e.fmt = 3'd7; e.illegal = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: pops the scoreboard on every output transfer and checks that a
  // stalled output holds its value into the next cycle.
  logic        hold = 1'b0;
  int          hold_rst;
  logic [31:0] h_inst, h_imm_a;
  logic [63:0] h_imm_b;
  logic [2:0]  h_fmt;
  logic        h_ill;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (!rst_ni) begin
        hold = 1'b0;
      end else begin
        if (hold && hold_rst == rst_count) begin
          chk("hold_inst", inst_a, h_inst);
          chk("hold_imm_a", imm_a, h_imm_a);
          chk("hold_imm_b", imm_b, h_imm_b);
          chk("hold_fmt", fmt_a, h_fmt);
          chk("hold_ill", ill_a, h_ill);
        end
        hold = 1'b0;
        if (out_valid_a && out_ready_i && !flush_i) begin
          if (q.size() == 0) begin
            chk("pop_empty_scoreboard", 1'b1, 1'b0);
          end else begin
            e = q.pop_front();
            chk("out_inst_a", inst_a, e.inst);
            chk("out_imm_a", imm_a, e.imm[31:0]);
            chk("out_fmt_a", fmt_a, e.fmt);
            chk("out_ill_a", ill_a, e.illegal);
            chk("out_inst_b", inst_b, e.inst);
            chk("out_imm_b", imm_b, e.imm);
            chk("out_fmt_b", fmt_b, e.fmt);
            chk("out_ill_b", ill_b, e.illegal);
          end
        end
        if (out_valid_a && !out_ready_i && !flush_i) begin
          hold = 1'b1; hold_rst = rst_count;
          h_inst = inst_a; h_imm_a = imm_a; h_imm_b = imm_b;
          h_fmt = fmt_a; h_ill = ill_a;
        end
      end
    end
  end

  // One cycle of stimulus, entered and left at posedge+1.
  task automatic drive(input logic v, input logic [31:0] w, input logic fl,
                       input logic ordy, output logic fired);
    exp_t e;
    in_valid_i  = v;
    in_inst_i   = w;
    flush_i     = fl;
    out_ready_i = fl ? 1'b0 : ordy;
    @(negedge clk_i);
    fired = v && in_ready_a && !fl;
    if (fired) begin
      e = ref_decode(w);
      q.push_back(e);
      if (e.illegal) begin
        if (m_cnt_a < 3) m_cnt_a++;
        if (m_cnt_b < 65535) m_cnt_b++;
      end
    end
    @(posedge clk_i);
    #1;
    if (fl) q.delete();
    chk("cnt_a", cnt_a, m_cnt_a);
    chk("cnt_b", cnt_b, m_cnt_b);
    chk("in_ready_a", in_ready_a, q.size() < 2);
    chk("in_ready_b", in_ready_b, q.size() < 2);
    chk("out_valid_a", out_valid_a, q.size() > 0);
    chk("out_valid_b", out_valid_b, q.size() > 0);
    in_valid_i = 1'b0;
    flush_i    = 1'b0;
  endtask

  task automatic send(input logic [31:0] w, input logic ordy);
    logic f;
    f = 1'b0;
    for (int i = 0; i < 20 && !f; i++) drive(1'b1, w, 1'b0, ordy, f);
    if (!f) chk("accept_timeout", 1'b0, 1'b1);
  endtask

  task automatic drain();
    logic f;
    for (int i = 0; i < 10 && (q.size() != 0 || out_valid_a); i++)
      drive(1'b0, 32'h0, 1'b0, 1'b1, f);
    chk("drain_empty", q.size(), 0);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_valid_a"}, out_valid_a, 1'b0);
    chk({tag, "_ready_a"}, in_ready_a, 1'b1);
    chk({tag, "_inst_a"}, inst_a, 32'h0);
    chk({tag, "_imm_a"}, imm_a, 32'h0);
    chk({tag, "_fmt_a"}, fmt_a, 3'd0);
    chk({tag, "_ill_a"}, ill_a, 1'b0);
    chk({tag, "_cnt_a"}, cnt_a, 2'd0);
    chk({tag, "_valid_b"}, out_valid_b, 1'b0);
    chk({tag, "_imm_b"}, imm_b, 64'h0);
    chk({tag, "_cnt_b"}, cnt_b, 16'd0);
  endtask

  localparam logic [6:0] OPS [11] = '{7'h03, 7'h13, 7'h67, 7'h73, 7'h23,
                                      7'h63, 7'h37, 7'h17, 7'h6F, 7'h33, 7'h7F};

  initial begin
    logic f;
    logic [31:0] w;
    int k;
    rst_ni = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0;
    in_inst_i = 32'h0; out_ready_i = 1'b0;
    #2;
    chk_reset_outputs("reset");
    @(posedge clk_i); #1;
    rst_ni = 1'b1;

    // addi x1,x0,-1: visible one cycle after acceptance
    drive(1'b1, 32'hFFF00093, 1'b0, 1'b1, f);
    chk("addi_fired", f, 1'b1);
    chk("addi_latency_valid", out_valid_a, 1'b1);
    chk("addi_imm", imm_a, 32'hFFFFFFFF);
    chk("addi_fmt", fmt_a, 3'd1);
    chk("addi_ill", ill_a, 1'b0);
    // sw x1,-4(x2)
    drive(1'b1, 32'hFE112E23, 1'b0, 1'b1, f);
    chk("sw_imm", imm_a, 32'hFFFFFFFC);
    chk("sw_fmt", fmt_a, 3'd2);
    // lui x5,0x80000 on the 64-bit instance
    drive(1'b1, 32'h800002B7, 1'b0, 1'b1, f);
    chk("lui_imm64", imm_b, 64'hFFFFFFFF80000000);
    chk("lui_fmt", fmt_b, 3'd4);
    drain();

    // three back-to-back words into a stalled output
    drive(1'b1, 32'h00100113, 1'b0, 1'b0, f);
    chk("b2b_w0", f, 1'b1);
    drive(1'b1, 32'h0020006F, 1'b0, 1'b0, f);
    chk("b2b_w1", f, 1'b1);
    chk("b2b_full_ready", in_ready_a, 1'b0);
    drive(1'b1, 32'hFE000EE3, 1'b0, 1'b0, f);
    chk("b2b_w2_refused", f, 1'b0);
    send(32'hFE000EE3, 1'b1);
    drain();

    // illegal opcode, then the same word discarded by flush
    drive(1'b1, 32'h0000007F, 1'b0, 1'b1, f);
    chk("ill_fmt", fmt_a, 3'd7);
    chk("ill_flag", ill_a, 1'b1);
    chk("ill_imm", imm_b, 64'h0);
    chk("ill_cnt", cnt_a, 2'd1);
    drain();
    drive(1'b1, 32'h0000007F, 1'b1, 1'b0, f);
    chk("flush_cnt", cnt_a, 2'd1);
    chk("flush_valid", out_valid_a, 1'b0);
    chk("flush_ready", in_ready_a, 1'b1);

    // five more illegal words saturate the 2-bit counter
    for (int i = 0; i < 5; i++) send(32'hFFFFFFFF, 1'b1);
    drain();
    chk("sat_cnt", cnt_a, 2'd3);

    // reset pulse with the buffer full
    drive(1'b1, 32'h12345037, 1'b0, 1'b0, f);
    drive(1'b1, 32'h0000000B, 1'b0, 1'b0, f);
    rst_ni = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    rst_count++;
    q.delete();
    m_cnt_a = 0; m_cnt_b = 0;
    in_valid_i = 1'b1; in_inst_i = 32'h0000007F; out_ready_i = 1'b1;
    @(posedge clk_i); #1;
    chk_reset_outputs("rst_held");
    rst_ni = 1'b1;
    drive(1'b1, 32'hABCDE017, 1'b0, 1'b1, f);
    chk("first_after_reset", f, 1'b1);

    // random traffic with random back-pressure and occasional flush
    for (int i = 0; i < 400; i++) begin
      k = $urandom_range(0, 10);
      w = $urandom();
      w[6:0] = ($urandom_range(0, 7) == 0) ? 7'($urandom()) : OPS[k];
      drive($urandom_range(0, 9) < 7, w, $urandom_range(0, 24) == 0,
            $urandom_range(0, 9) < 6, f);
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
